// File: rtl/calc_pkg.sv
// calc_pkg: shared operator codes, FSM state encoding and operand limit helper.
package calc_pkg;
  localparam logic [1:0] OP_PLUS = 2'd1;
  localparam logic [1:0] OP_MIN = 2'd2;
  typedef enum logic [2:0] {
    A_ENTRY = 3'd0,
    OP_SEL  = 3'd1,
    B_ENTRY = 3'd2,
    RESULT  = 3'd3,
    ERROR   = 3'd4
  } state_t;
  function automatic int max_val(input int digits);
    int v;
    v = 1;
    for (int i = 0; i < digits; i++) v = v * 10;
    return v - 1;
  endfunction
endpackage

// File: rtl/key_event_qual.sv
// key_event_qual: turns a held, stable, well-formed key tuple into one strobe per press.
module key_event_qual #(
  parameter int SETTLE = 16,
  parameter int RELEASE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       any_btn,
  input  logic       is_number,
  input  logic       is_op,
  input  logic       is_eq,
  input  logic [3:0] num_val,
  input  logic [1:0] op_val,
  output logic       key_strobe,
  output logic       ev_num,
  output logic       ev_op,
  output logic       ev_eq,
  output logic [3:0] ev_digit,
  output logic [1:0] ev_opv
);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int RW = $clog2(RELEASE + 1);
  logic [9:0] tup, tup_q;
  logic [SW-1:0] cnt, cnt_nxt;
  logic [RW-1:0] rel;
  logic armed, valid, fire;
  assign tup = {is_number, is_op, is_eq, num_val, op_val};
  assign cnt_nxt = !any_btn ? '0 : tup != tup_q ? SW'(1) : cnt == SW'(SETTLE) ? cnt : cnt + 1'b1;
  assign valid = ({is_number, is_op, is_eq} inside {3'b100, 3'b010, 3'b001})
              && (!is_number || num_val <= 4'd9) && (!is_op || op_val inside {2'd1, 2'd2});
  // Fires only on the cycle the count first reaches SETTLE, so a long hold gives one event.
  assign fire = armed && valid && cnt_nxt == SW'(SETTLE) && cnt != SW'(SETTLE);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tup_q <= '0;
      cnt <= '0;
      rel <= '0;
      armed <= 1'b1;
      key_strobe <= 1'b0;
      {ev_num, ev_op, ev_eq, ev_digit, ev_opv} <= '0;
    end else begin
      tup_q <= tup;
      cnt <= cnt_nxt;
      rel <= any_btn ? '0 : rel == RW'(RELEASE) ? rel : rel + 1'b1;
      key_strobe <= fire;
      if (fire) begin
        armed <= 1'b0;
        {ev_num, ev_op, ev_eq, ev_digit, ev_opv} <= tup;
      end else if (!any_btn && rel >= RW'(RELEASE - 1)) armed <= 1'b1;
    end
endmodule

// File: rtl/calc_entry_fsm.sv
// calc_entry_fsm: key events drive operand entry, +/- evaluation and the value shown on the display.
module calc_entry_fsm
  import calc_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int SETTLE = 16,
  parameter int RELEASE = 16,
  parameter int VW = 14
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          any_btn,
  input  logic          is_number,
  input  logic          is_op,
  input  logic          is_eq,
  input  logic [3:0]    num_val,
  input  logic [1:0]    op_val,
  output logic          key_strobe,
  output logic [VW-1:0] disp_val,
  output logic          disp_neg,
  output logic          err,
  output logic [2:0]    state_dbg
);
  localparam int AW = VW + 2;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int MAXV = max_val(DIGITS);
  logic ev_num, ev_op, ev_eq;
  logic [3:0] ev_digit;
  logic [1:0] ev_opv, op;
  logic signed [AW-1:0] a, b, res;
  logic [CW-1:0] acnt, bcnt;
  logic ovf;
  state_t state;
  function automatic logic [AW-1:0] mag(input logic signed [AW-1:0] x);
    return x[AW-1] ? -x : x;
  endfunction
  key_event_qual #(.SETTLE(SETTLE), .RELEASE(RELEASE)) u_qual (
    .clk(clk), .reset_n(reset_n), .any_btn(any_btn), .is_number(is_number), .is_op(is_op),
    .is_eq(is_eq), .num_val(num_val), .op_val(op_val), .key_strobe(key_strobe),
    .ev_num(ev_num), .ev_op(ev_op), .ev_eq(ev_eq), .ev_digit(ev_digit), .ev_opv(ev_opv)
  );
  assign res = op == OP_MIN ? a - b : a + b;
  assign ovf = mag(res) > AW'(MAXV);
  assign state_dbg = state;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= A_ENTRY;
      a <= '0;
      b <= '0;
      acnt <= '0;
      bcnt <= '0;
      op <= OP_PLUS;
      disp_val <= '0;
      disp_neg <= 1'b0;
      err <= 1'b0;
    end else begin
      disp_val <= state == ERROR ? '0 : state == B_ENTRY ? VW'(mag(b)) : VW'(mag(a));
      disp_neg <= state != ERROR && state != B_ENTRY && a[AW-1];
      err <= state == ERROR;
      if (key_strobe)
        case (state)
          A_ENTRY:
            if (ev_num && acnt < CW'(DIGITS)) begin
              a <= a * AW'(10) + AW'(ev_digit);
              acnt <= acnt + 1'b1;
            end else if (ev_op) begin
              op <= ev_opv;
              state <= OP_SEL;
            end
          OP_SEL:
            if (ev_op) op <= ev_opv;
            else if (ev_num) begin
              b <= AW'(ev_digit);
              bcnt <= CW'(1);
              state <= B_ENTRY;
            end
          B_ENTRY:
            if (ev_num && bcnt < CW'(DIGITS)) begin
              b <= b * AW'(10) + AW'(ev_digit);
              bcnt <= bcnt + 1'b1;
            end else if (ev_op || ev_eq) begin
              if (ovf) state <= ERROR;
              else begin
                a <= res;
                state <= ev_op ? OP_SEL : RESULT;
                if (ev_op) op <= ev_opv;
              end
            end
          RESULT:
            if (ev_num) begin
              a <= AW'(ev_digit);
              acnt <= CW'(1);
              state <= A_ENTRY;
            end else if (ev_op) begin
              op <= ev_opv;
              state <= OP_SEL;
            end
          ERROR:
            if (ev_eq) begin
              a <= '0;
              b <= '0;
              acnt <= '0;
              bcnt <= '0;
              op <= OP_PLUS;
              state <= A_ENTRY;
            end
          default: state <= A_ENTRY;
        endcase
    end
endmodule

// File: tb/tb_calc_entry_fsm.sv
// tb_calc_entry_fsm: directed key sequences, expected display pushed per event and checked by a monitor.
module tb_calc_entry_fsm;
  localparam int P = 10, M = 11, E = 12;
  logic clk = 1'b0, reset_n = 1'b0, any_btn = 1'b0, is_number = 1'b0, is_op = 1'b0, is_eq = 1'b0;
  logic [3:0] num_val = '0;
  logic [1:0] op_val = '0;
  logic key_strobe, disp_neg, err;
  logic [13:0] disp_val;
  logic [2:0] state_dbg;
  typedef struct packed {
    logic [13:0] v;
    logic n;
    logic e;
    logic [2:0] s;
  } exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0, strobes = 0;

  always #5 clk = ~clk;

  calc_entry_fsm #(.DIGITS(4), .SETTLE(4), .RELEASE(4), .VW(14)) dut (
    .clk(clk), .reset_n(reset_n), .any_btn(any_btn), .is_number(is_number), .is_op(is_op),
    .is_eq(is_eq), .num_val(num_val), .op_val(op_val), .key_strobe(key_strobe),
    .disp_val(disp_val), .disp_neg(disp_neg), .err(err), .state_dbg(state_dbg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic drive(input int k);
    any_btn = k >= 0;
    is_number = k >= 0 && k < 10;
    is_op = k == P || k == M;
    is_eq = k == E;
    num_val = (k >= 0 && k < 10) ? 4'(k) : 4'd0;
    op_val = k < 0 ? 2'd0 : k == M ? 2'd2 : 2'd1;
  endtask

  task automatic key(input int k, input int v, input bit n, input bit e, input int s);
    int s0;
    q.push_back('{14'(v), n, e, 3'(s)});
    s0 = strobes;
    drive(k);
    repeat (10) @(negedge clk);
    drive(-1);
    repeat (10) @(negedge clk);
    chk($sformatf("strobe_count_key%0d", k), 32'(strobes - s0), 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Display settles two cycles after the strobe: state updates, then disp_* registers follow.
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (key_strobe === 1'b1) begin
      strobes++;
      repeat (2) @(posedge clk);
      #1;
      if (q.size() == 0) chk("unexpected_strobe", 32'(q.size()), 32'd1);
      else begin
        e = q.pop_front();
        chk("event_disp{val,neg,err,state}", 32'({disp_val, disp_neg, err, state_dbg}), 32'(e));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    drive(-1);
    do_reset();
    chk("reset_disp_val", 32'(disp_val), 0);
    chk("reset_disp_neg", 32'(disp_neg), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_state", 32'(state_dbg), 0);
    chk("reset_strobe", 32'(key_strobe), 0);
    key(1, 1, 0, 0, 0);
    key(2, 12, 0, 0, 0);
    key(3, 123, 0, 0, 0);

    do_reset();
    key(1, 1, 0, 0, 0);
    key(2, 12, 0, 0, 0);
    key(P, 12, 0, 0, 1);
    key(3, 3, 0, 0, 2);
    key(0, 30, 0, 0, 2);
    key(E, 42, 0, 0, 3);
    key(7, 7, 0, 0, 0);

    do_reset();
    key(5, 5, 0, 0, 0);
    key(M, 5, 0, 0, 1);
    key(9, 9, 0, 0, 2);
    key(E, 4, 1, 0, 3);
    key(P, 4, 1, 0, 1);
    key(2, 2, 0, 0, 2);
    key(E, 2, 1, 0, 3);

    do_reset();
    key(9, 9, 0, 0, 0);
    key(9, 99, 0, 0, 0);
    key(9, 999, 0, 0, 0);
    key(9, 9999, 0, 0, 0);
    key(P, 9999, 0, 0, 1);
    key(1, 1, 0, 0, 2);
    key(E, 0, 0, 1, 4);
    key(5, 0, 0, 1, 4);
    key(E, 0, 0, 0, 0);

    do_reset();
    q.push_back('{14'd3, 1'b0, 1'b0, 3'd0});
    s0 = strobes;
    drive(3);
    repeat (200) @(negedge clk);
    drive(-1);
    repeat (10) @(negedge clk);
    chk("long_hold_strobes", 32'(strobes - s0), 1);
    s0 = strobes;
    drive(4);
    repeat (3) @(negedge clk);
    drive(-1);
    repeat (10) @(negedge clk);
    chk("glitch_strobes", 32'(strobes - s0), 0);
    s0 = strobes;
    for (int i = 0; i < 20; i++) begin
      drive(i % 2 == 0 ? 1 : 2);
      repeat (2) @(negedge clk);
    end
    drive(-1);
    repeat (10) @(negedge clk);
    chk("unstable_tuple_strobes", 32'(strobes - s0), 0);

    do_reset();
    key(1, 1, 0, 0, 0);
    key(2, 12, 0, 0, 0);
    key(3, 123, 0, 0, 0);
    key(4, 1234, 0, 0, 0);
    key(5, 1234, 0, 0, 0);
    s0 = strobes;
    drive(6);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midreset_disp_val", 32'(disp_val), 0);
    chk("midreset_state", 32'(state_dbg), 0);
    chk("midreset_strobe", 32'(key_strobe), 0);
    repeat (3) @(negedge clk);
    chk("midreset_no_strobe", 32'(strobes - s0), 0);
    q.push_back('{14'd6, 1'b0, 1'b0, 3'd0});
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    drive(-1);
    repeat (10) @(negedge clk);
    chk("held_after_reset_strobes", 32'(strobes - s0), 1);

    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
